gate16_bist: RTL and testbench
==============================

GATE16_BIST -- requirements
Module: gate16_bist

Interface
REQ-001 The block SHALL have parameter NUM_RANDOM, default 64, giving the number of pseudo-random vectors per run (range 1..251).
REQ-002 The block SHALL have parameter SEED, default 16'hACE1, giving the LFSR seed loaded on each start (must be nonzero).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a test run; sampled only in IDLE or DONE.
REQ-006 The block SHALL have port op, input, 2 bits: gate-under-test function, where 00=AND, 01=OR, 10=XOR, 11=NAND.
REQ-007 The block SHALL have port dut_a, output, 16 bits: stimulus operand a to the 16-bit gate under test.
REQ-008 The block SHALL have port dut_b, output, 16 bits: stimulus operand b.
REQ-009 The block SHALL have port dut_out, input, 16 bits: response from the gate under test.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: high while in DONE.
REQ-012 The block SHALL have port pass, output, 1 bit: valid when done is high; 1 if no mismatches occurred.
REQ-013 The block SHALL have port fail_count, output, 8 bits: number of mismatching vectors, saturating at 255.
REQ-014 The block SHALL have port first_fail_idx, output, 8 bits: index of the first mismatching vector; 8'hFF if there was none.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, APPLY, CHECK and DONE.
REQ-016 From IDLE or DONE, start=1 SHALL cause a transition to APPLY and perform the following on that same edge: latch op; load the LFSR with SEED; clear vector index, fail_count and pass; set first_fail_idx to 8'hFF.
REQ-017 APPLY SHALL drive vector[idx] on dut_a/dut_b and then go to CHECK on the next edge.
REQ-018 CHECK SHALL hold dut_a/dut_b stable, compare dut_out against expected(op_latched, dut_a, dut_b), then either increment idx and return to APPLY, or go to DONE after the last vector.
REQ-019 Each vector SHALL take exactly 2 cycles, and a run SHALL consist of 4+NUM_RANDOM vectors.
REQ-020 done SHALL rise 2*(4+NUM_RANDOM) cycles after the start edge; with defaults, this is 136 cycles.
REQ-021 Vectors 0..3 SHALL be the directed corners, as (a,b): (0000,0000), (FFFF,0000), (0000,FFFF), (FFFF,FFFF).
REQ-022 For vectors 4.. (random), the block SHALL drive a = lfsr and b = {lfsr[7:0], lfsr[15:8]} ^ 16'h5A5A.
REQ-023 The LFSR SHALL advance one step on each CHECK->APPLY edge of a random vector.
REQ-024 The LFSR SHALL be a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1, shifting left, with feedback bit = l[15]^l[13]^l[12]^l[10].
REQ-025 Expected values SHALL be computed bitwise over 16 bits with no width extension; NAND is the bitwise inversion of AND.
REQ-026 On a mismatch, fail_count SHALL increment unless it is already 255, and first_fail_idx SHALL capture idx only if it is still 8'hFF.
REQ-027 On entry to DONE, pass SHALL be set to (fail_count==0 after the final compare).
REQ-028 In DONE, done SHALL be 1, busy SHALL be 0, and results SHALL be held until the next start or reset.
REQ-029 start while busy SHALL be ignored, and op changes mid-run SHALL have no effect.
REQ-030 In IDLE and DONE, dut_a and dut_b SHALL be 16'h0000.
REQ-031 start asserted in the same cycle as the DONE entry edge SHALL be ignored, because start is sampled in DONE only from the following cycle.

Reset
REQ-032 With rst_n=0 at a rising edge, the block SHALL enter IDLE and clear the following outputs: busy=0, done=0, pass=0, fail_count=0, first_fail_idx=8'hFF, dut_a=dut_b=0, LFSR=SEED.
REQ-033 Reset SHALL take priority over start in the same cycle.
REQ-034 Reset mid-run SHALL abort the run with no partial results retained.

Structure
REQ-035 A shared package SHALL hold the op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND), the FSM state encodings, the four directed-vector constants, the LFSR tap mask and the 5A5A mask.
REQ-036 The LFSR SHALL be implemented as sub-module lfsr16, with ports: clk, rst_n, load, seed[15:0], step, q[15:0].
REQ-037 The expected-value function and the comparator SHALL be implemented inline in gate16_bist.

Verification
REQ-038 Correct OR model on dut_*, op=01, start for one cycle: the bench SHALL check done high at start+136, pass=1, fail_count=0 and first_fail_idx=FF.
REQ-039 OR model with dut_out[0] stuck at 0, op=01: the bench SHALL check that the first failure is at vector 1 (FFFF,0000), first_fail_idx=01, pass=0, and fail_count equals the count from the reference model.
REQ-040 Correct AND model but op=10 (XOR expected): the bench SHALL check first_fail_idx=01 on vector (FFFF,0000) (expected FFFF, got 0000), and pass=0.
REQ-041 Run with NUM_RANDOM=251 and a DUT driving dut_out=~expected: the bench SHALL check fail_count saturates at FF, first_fail_idx=00 and pass=0.
REQ-042 Assert rst_n=0 at cycle 20 of a run: the bench SHALL check state IDLE, busy=0, done=0 and dut_a=0 on the next cycle; a subsequent start SHALL reproduce identical vectors from SEED.
REQ-043 Pulse start at cycles 5 and 40 of a run, toggling op mid-run: the bench SHALL check that the run length is still 136 cycles and that results match the originally latched op.

Source files
------------

// File: rtl/gate16_bist_pkg.sv
// Shared types and constants for the 16-bit gate BIST: op and state encodings,
// directed corner vectors, LFSR taps and vector-generation helpers.
package gate16_bist_pkg;

  localparam int unsigned VEC_W        = 16;
  localparam int unsigned NUM_DIRECTED = 4;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    APPLY = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_e;

  typedef struct packed {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
  } vec_t;

  localparam vec_t DIR_VEC0 = {16'h0000, 16'h0000};
  localparam vec_t DIR_VEC1 = {16'hFFFF, 16'h0000};
  localparam vec_t DIR_VEC2 = {16'h0000, 16'hFFFF};
  localparam vec_t DIR_VEC3 = {16'hFFFF, 16'hFFFF};

  // x^16+x^14+x^13+x^11+1 -> taps at bits 15,13,12,10
  localparam logic [VEC_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [VEC_W-1:0] B_MASK    = 16'h5A5A;

  function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] l);
    return {l[VEC_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic vec_t rand_vec(input logic [VEC_W-1:0] l);
    vec_t v;
    v.a = l;
    v.b = {l[7:0], l[15:8]} ^ B_MASK;
    return v;
  endfunction

  function automatic vec_t dir_vec(input logic [1:0] i);
    vec_t v;
    case (i)
      2'd0:    v = DIR_VEC0;
      2'd1:    v = DIR_VEC1;
      2'd2:    v = DIR_VEC2;
      default: v = DIR_VEC3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gate16_bist_lfsr16.sv
// 16-bit Fibonacci LFSR, left-shifting; reset and load both restore the seed.
module lfsr16
  import gate16_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VEC_W-1:0] seed,
  input  logic             step,
  output logic [VEC_W-1:0] q
);

  logic [VEC_W-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/gate16_bist.sv
// BIST sequencer for a 16-bit two-input gate: applies 4 directed corners plus
// NUM_RANDOM LFSR vectors, two cycles each, and tallies mismatches.
module gate16_bist
  import gate16_bist_pkg::*;
#(
  parameter int unsigned NUM_RANDOM = 64,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  output logic [15:0] dut_a,
  output logic [15:0] dut_b,
  input  logic [15:0] dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [7:0]  first_fail_idx
);

  localparam int unsigned NUM_VEC  = NUM_DIRECTED + NUM_RANDOM;
  localparam logic [7:0]  LAST_IDX = 8'(NUM_VEC - 1);
  localparam logic [7:0]  FIRST_RND = 8'(NUM_DIRECTED);
  localparam logic [7:0]  NO_FAIL  = 8'hFF;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [7:0]       idx_q, idx_d;
  vec_t             vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       fail_q, fail_d;
  logic [7:0]       first_q, first_d;
  logic             lfsr_load_c, lfsr_step_c;
  logic [VEC_W-1:0] lfsr_val;
  logic [VEC_W-1:0] expect_c;
  logic             mismatch_c;

  function automatic logic [VEC_W-1:0] expected(input op_e o, input logic [VEC_W-1:0] a,
                                                input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    case (o)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load_c),
    .seed  (SEED),
    .step  (lfsr_step_c),
    .q     (lfsr_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      idx_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      first_q <= NO_FAIL;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      first_q <= first_d;
    end
  end

  // Vector registers are loaded on the edge entering APPLY so they hold through CHECK.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    first_d     = first_q;
    lfsr_load_c = 1'b0;
    lfsr_step_c = 1'b0;
    expect_c    = expected(op_q, vec_q.a, vec_q.b);
    mismatch_c  = (dut_out != expect_c);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = APPLY;
          op_d        = op_e'(op);
          idx_d       = '0;
          vec_d       = dir_vec(2'd0);
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_d      = '0;
          first_d     = NO_FAIL;
          lfsr_load_c = 1'b1;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        if (mismatch_c) begin
          if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
          if (first_q == NO_FAIL) first_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_d == 8'd0);
          vec_d   = '0;
        end else begin
          state_d     = APPLY;
          idx_d       = idx_q + 8'd1;
          lfsr_step_c = (idx_q >= FIRST_RND);
          if (idx_d < FIRST_RND) begin
            vec_d = dir_vec(idx_d[1:0]);
          end else begin
            vec_d = rand_vec(lfsr_step_c ? lfsr_next(lfsr_val) : lfsr_val);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_a          = vec_q.a;
  assign dut_b          = vec_q.b;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = first_q;

endmodule

// File: tb/tb_gate16_bist.sv
// Self-checking bench for gate16_bist: a behavioural gate model drives dut_out and
// a reference model predicts vectors, timing and results.
module tb_gate16_bist;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [15:0] dut_a, dut_b, dut_out;
  logic        busy, done, pass;
  logic [7:0]  fail_count, first_fail_idx;
  logic [15:0] dut_a_s, dut_b_s, dut_out_s;
  logic        busy_s, done_s, pass_s;
  logic [7:0]  fail_count_s, first_fail_idx_s;

  logic [1:0]  gop;
  logic [1:0]  gmode;
  int          total, bad;
  logic [31:0] cap_q[$];

  localparam logic [15:0] SEED = 16'hACE1;

  function automatic logic [15:0] ref_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // mode 0: healthy gate, 1: bit 0 stuck at 0, 2: every bit inverted
  function automatic logic [15:0] gate(input logic [1:0] g, input logic [1:0] m,
                                       input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = ref_op(g, a, b);
    if (m == 2'd1) r = r & 16'hFFFE;
    else if (m == 2'd2) r = ~r;
    return r;
  endfunction

  function automatic logic [31:0] ref_vec(input int k);
    logic [15:0] l, a, b;
    logic        fb;
    case (k)
      0: return {16'h0000, 16'h0000};
      1: return {16'hFFFF, 16'h0000};
      2: return {16'h0000, 16'hFFFF};
      3: return {16'hFFFF, 16'hFFFF};
      default: ;
    endcase
    l = SEED;
    for (int j = 0; j < k - 4; j++) begin
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      l  = 16'((l << 1) | 16'(fb));
    end
    a = l;
    b = 16'((l << 8) | (l >> 8)) ^ 16'h5A5A;
    return {a, b};
  endfunction

  task automatic model_run(input int nvec, input logic [1:0] lop, input logic [1:0] g,
                           input logic [1:0] m, output int fc, output int ffi);
    logic [31:0] v;
    fc  = 0;
    ffi = 255;
    for (int k = 0; k < nvec; k++) begin
      v = ref_vec(k);
      if (gate(g, m, v[31:16], v[15:0]) !== ref_op(lop, v[31:16], v[15:0])) begin
        if (fc < 255) fc++;
        if (ffi == 255) ffi = k;
      end
    end
  endtask

  assign dut_out   = gate(gop, gmode, dut_a, dut_b);
  assign dut_out_s = gate(gop, gmode, dut_a_s, dut_b_s);

  gate16_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dut_a(dut_a), .dut_b(dut_b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx)
  );

  gate16_bist #(.NUM_RANDOM(251)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dut_a(dut_a_s), .dut_b(dut_b_s), .dut_out(dut_out_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_count(fail_count_s), .first_fail_idx(first_fail_idx_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns just after the start edge (cycle 0).
  task automatic launch(input logic [1:0] o);
    op    = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles from the start edge until done; captures the vector held in each CHECK cycle.
  task automatic wait_done(output int cyc);
    cyc = 0;
    cap_q.delete();
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc % 2 == 1 && !done) cap_q.push_back({dut_a, dut_b});
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %0b want 0", pass); end
    total++; if (fail_count !== 8'h00) begin bad++; $display("FAIL reset_fc: got %h want 00", fail_count); end
    total++; if (first_fail_idx !== 8'hFF) begin bad++; $display("FAIL reset_ffi: got %h want ff", first_fail_idx); end
    total++; if ({dut_a, dut_b} !== 32'h0) begin bad++; $display("FAIL reset_vec: got %h want 0", {dut_a, dut_b}); end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_saturate();
    int cyc;
    logic [1:0] o;
    pulse_reset();
    o     = 2'($urandom_range(0, 3));
    gop   = o;
    gmode = 2'd2;
    launch(o);
    cyc = 0;
    while (!done_s && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++; if (cyc != 510) begin bad++; $display("FAIL sat_len: got %0d want 510", cyc); end
    total++; if (fail_count_s !== 8'hFF) begin bad++; $display("FAIL sat_fc: got %h want ff", fail_count_s); end
    total++; if (first_fail_idx_s !== 8'h00) begin bad++; $display("FAIL sat_ffi: got %h want 00", first_fail_idx_s); end
    total++; if (pass_s !== 1'b0) begin bad++; $display("FAIL sat_pass: got %0b want 0", pass_s); end
    gmode = 2'd0;
  endtask

  task automatic test_or_correct();
    int cyc;
    logic [31:0] v;
    gop   = 2'b01;
    gmode = 2'd0;
    launch(2'b01);
    wait_done(cyc);
    total++; if (cyc != 136) begin bad++; $display("FAIL or_len: got %0d want 136", cyc); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL or_pass: got %0b want 1", pass); end
    total++; if (fail_count !== 8'h00) begin bad++; $display("FAIL or_fc: got %h want 00", fail_count); end
    total++; if (first_fail_idx !== 8'hFF) begin bad++; $display("FAIL or_ffi: got %h want ff", first_fail_idx); end
    total++; if (busy !== 1'b0 || {dut_a, dut_b} !== 32'h0) begin
      bad++; $display("FAIL or_done_idle: got busy=%0b vec=%h want 0 0", busy, {dut_a, dut_b});
    end
    total++; if (cap_q.size() != 68) begin bad++; $display("FAIL or_nvec: got %0d want 68", cap_q.size()); end
    foreach (cap_q[k]) begin
      v = ref_vec(k);
      total++; if (cap_q[k] !== v) begin bad++; $display("FAIL or_vec%0d: got %h want %h", k, cap_q[k], v); end
    end
  endtask

  task automatic test_stuck();
    int cyc, fc, ffi;
    gop   = 2'b01;
    gmode = 2'd1;
    model_run(68, 2'b01, 2'b01, 2'd1, fc, ffi);
    launch(2'b01);
    wait_done(cyc);
    total++; if (first_fail_idx !== 8'h01) begin bad++; $display("FAIL stuck_ffi: got %h want 01", first_fail_idx); end
    total++; if (fail_count !== 8'(fc)) begin bad++; $display("FAIL stuck_fc: got %0d want %0d", fail_count, fc); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL stuck_pass: got %0b want 0", pass); end
    gmode = 2'd0;
  endtask

  task automatic test_op_mismatch();
    int cyc, fc, ffi;
    gop   = 2'b00;
    gmode = 2'd0;
    model_run(68, 2'b10, 2'b00, 2'd0, fc, ffi);
    launch(2'b10);
    wait_done(cyc);
    total++; if (first_fail_idx !== 8'h01) begin bad++; $display("FAIL opmm_ffi: got %h want 01", first_fail_idx); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL opmm_pass: got %0b want 0", pass); end
    total++; if (fail_count !== 8'(fc)) begin bad++; $display("FAIL opmm_fc: got %0d want %0d", fail_count, fc); end
  endtask

  task automatic test_random();
    int cyc, fc, ffi;
    logic [1:0] o;
    for (int r = 0; r < 6; r++) begin
      o     = 2'($urandom_range(0, 3));
      gop   = (r % 2 == 0) ? o : 2'($urandom_range(0, 3));
      gmode = 2'($urandom_range(0, 2));
      model_run(68, o, gop, gmode, fc, ffi);
      launch(o);
      wait_done(cyc);
      total++; if (fail_count !== 8'(fc) || first_fail_idx !== 8'(ffi) || pass !== (fc == 0)) begin
        bad++;
        $display("FAIL rand%0d: got fc=%0d ffi=%0d pass=%0b want fc=%0d ffi=%0d pass=%0b",
                 r, fail_count, first_fail_idx, pass, fc, ffi, (fc == 0));
      end
    end
    gmode = 2'd0;
  endtask

  task automatic test_reset_midrun();
    int cyc;
    logic [31:0] v;
    logic [31:0] early[$];
    gop   = 2'b10;
    gmode = 2'd1;
    launch(2'b10);
    for (int c = 1; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (c % 2 == 1) early.push_back({dut_a, dut_b});
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done: got %0b want 0", done); end
    total++; if (dut_a !== 16'h0) begin bad++; $display("FAIL mid_dut_a: got %h want 0", dut_a); end
    total++; if (fail_count !== 8'h0 || first_fail_idx !== 8'hFF) begin
      bad++; $display("FAIL mid_results: got fc=%h ffi=%h want 00 ff", fail_count, first_fail_idx);
    end
    rst_n = 1'b1;
    gmode = 2'd0;
    launch(2'b10);
    wait_done(cyc);
    total++; if (cyc != 136 || pass !== 1'b1) begin
      bad++; $display("FAIL mid_rerun: got len=%0d pass=%0b want 136 1", cyc, pass);
    end
    foreach (early[k]) begin
      v = ref_vec(k);
      total++; if (early[k] !== v || cap_q[k] !== v) begin
        bad++; $display("FAIL mid_vec%0d: got %h/%h want %h", k, early[k], cap_q[k], v);
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    gop   = 2'b10;
    gmode = 2'd0;
    launch(2'b10);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 4)  begin start = 1'b1; op = 2'b00; end
      if (cyc == 5)  start = 1'b0;
      if (cyc == 39) begin start = 1'b1; op = 2'b01; end
      if (cyc == 40) start = 1'b0;
    end
    total++; if (cyc != 136) begin bad++; $display("FAIL ign_len: got %0d want 136", cyc); end
    total++; if (pass !== 1'b1 || fail_count !== 8'h0) begin
      bad++; $display("FAIL ign_result: got pass=%0b fc=%0d want 1 0", pass, fail_count);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [1:0] o;
    o     = 2'($urandom_range(0, 3));
    gop   = o;
    gmode = 2'd0;
    launch(o);
    for (int c = 1; c < 136; c++) begin
      @(posedge clk);
      #1;
    end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_early: got done=%0b want 0", done); end
    start = 1'b1;
    @(posedge clk);
    #1;
    total++; if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_entry: got done=%0b busy=%0b want 1 0", done, busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_restart: got done=%0b busy=%0b want 0 1", done, busy);
    end
    wait_done(cyc);
    total++; if (cyc != 136 || pass !== 1'b1) begin
      bad++; $display("FAIL b2b_run: got len=%0d pass=%0b want 136 1", cyc, pass);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    gop   = 2'b00;
    gmode = 2'd0;
    total = 0;
    bad   = 0;
    test_reset();
    test_saturate();
    test_or_correct();
    test_stuck();
    test_op_mismatch();
    test_random();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
